// File: rtl/spi_reg_ctrl_pkg.sv
// Shared constants and types for the SPI register controller.
package spi_reg_pkg;

    // Register map
    localparam logic [6:0] ADDR_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY   = 7'h04;

    // Frame geometry; the bit counter must be able to hold FRAME_BITS + 1
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StCommit = 2'd2
    } state_e;

    // [15] R/W (1 = write), [14:8] address, [7:0] data
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } frame_t;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with rise/fall detection.
// SYNC_STAGES must be at least 2. Edges compare the last two stages; level_o is
// the fully synchronised (oldest) stage.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // sync_q[0] is the newest sample, sync_q[SYNC_STAGES-1] the oldest
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign fall_o  = ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Write-only SPI mode-0 peripheral: deserialises 16-bit frames and commits them
// into a 5-entry register file driving the PWM / output-enable datapath.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_i,
    input  logic       copi_i,
    input  logic       ncs_i,
    output logic [7:0] en_reg_out_7_0_o,
    output logic [7:0] en_reg_out_15_8_o,
    output logic [7:0] en_reg_pwm_7_0_o,
    output logic [7:0] en_reg_pwm_15_8_o,
    output logic [7:0] pwm_duty_cycle_o,
    output logic       txn_done_o,
    output logic       txn_err_o
);

    localparam logic [CNT_W-1:0] CntFull = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CntSat  = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [6:0]       MaxAddr = 7'(MAX_ADDR);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic copi_lvl, copi_rise, copi_fall;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (sclk_i),
        .level_o (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // Chip select idles deselected so reset does not look like a frame start
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_ncs (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (ncs_i),
        .level_o (ncs_lvl),
        .rise_o  (ncs_rise),
        .fall_o  (ncs_fall)
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_copi (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (copi_i),
        .level_o (copi_lvl),
        .rise_o  (copi_rise),
        .fall_o  (copi_fall)
    );

    // Edge outputs this datapath has no use for
    logic unused_edges;
    assign unused_edges = sclk_lvl ^ sclk_fall ^ copi_rise ^ copi_fall;

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    frame_t                frame;
    logic                  frame_ok;
    logic                  commit_we;
    logic                  done_d, err_d;
    logic                  done_q, err_q;
    logic [7:0]            out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;

    assign frame = frame_t'(shift_q);

    // A select that is already low on return to idle (fell during commit)
    // still starts a frame, hence the level term alongside the edge.
    logic start_frame;
    assign start_frame = ncs_fall | ~ncs_lvl;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start_frame) state_d = StShift;
            StShift:  if (ncs_rise)    state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: commit decision and status pulses
    always_comb begin
        frame_ok  = (cnt_q == CntFull) && frame.rw && (frame.addr <= MaxAddr);
        commit_we = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (state_q == StCommit) begin
            commit_we = frame_ok;
            done_d    = frame_ok;
            err_d     = ~frame_ok;
        end
    end

    // Shift register and saturating bit counter; a deselect wins over a
    // coincident final sclk rise, so that edge is not counted.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start_frame) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (sclk_rise && !ncs_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_lvl};
                    if (cnt_q != CntSat) cnt_d = cnt_q + CntOne;
                end
            end
            default: ;
        endcase
    end

    // Frame capture state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register file and status pulses; registers only change on a valid commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo_q <= '0;
            out_hi_q <= '0;
            pwm_lo_q <= '0;
            pwm_hi_q <= '0;
            duty_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            if (commit_we) begin
                case (frame.addr)
                    ADDR_OUT_LO: out_lo_q <= frame.data;
                    ADDR_OUT_HI: out_hi_q <= frame.data;
                    ADDR_PWM_LO: pwm_lo_q <= frame.data;
                    ADDR_PWM_HI: pwm_hi_q <= frame.data;
                    ADDR_DUTY:   duty_q   <= frame.data;
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0_o  = out_lo_q;
    assign en_reg_out_15_8_o = out_hi_q;
    assign en_reg_pwm_7_0_o  = pwm_lo_q;
    assign en_reg_pwm_15_8_o = pwm_hi_q;
    assign pwm_duty_cycle_o  = duty_q;
    assign txn_done_o        = done_q;
    assign txn_err_o         = err_q;

endmodule
